// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single data-memory port between the CPU MEM/WB stage and the
//   graphics processor. Round-robin arbitration at transaction boundaries,
//   beat-by-beat sequencing of GP bursts, cpu_stall while the CPU is locked out.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   cpu_req/addr/we/din      CPU single access (we==0 -> read)
//   cpu_dout, cpu_stall      read data (cycle after issue), hold-request
//   gp_req/addr/len/wr       GP burst request, held until gp_grant
//   gp_wdata                 write data for the current beat
//   gp_grant/wack/rvalid/    burst accepted / write beat consumed /
//   gp_rdata/done            read data valid / read data / burst finished
//   mem_addr/we/re/din       memory port towards the dcache
//   mem_dout, mem_ready      memory read data (1-cycle latency), accept strobe
module dmem_port_arbiter #(
    parameter int BURST_MAX = 8,
    parameter int LEN_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic [31:0]      cpu_addr,
    input  logic [3:0]       cpu_we,
    input  logic [31:0]      cpu_din,
    output logic [31:0]      cpu_dout,
    output logic             cpu_stall,
    input  logic             gp_req,
    input  logic [31:0]      gp_addr,
    input  logic [LEN_W-1:0] gp_len,
    input  logic             gp_wr,
    input  logic [31:0]      gp_wdata,
    output logic             gp_grant,
    output logic             gp_wack,
    output logic             gp_rvalid,
    output logic [31:0]      gp_rdata,
    output logic             gp_done,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_we,
    output logic             mem_re,
    output logic [31:0]      mem_din,
    input  logic [31:0]      mem_dout,
    input  logic             mem_ready
);

    typedef enum logic [1:0] {IDLE, GP_BURST, GP_DRAIN} state_t;

    state_t           state_q, state_d;
    logic             last_gp_q, last_gp_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      addr_q, addr_d;
    logic             wr_q, wr_d;
    logic             gp_rvalid_q, gp_rvalid_d;

    // Requests are masked while reset is held so the combinational outputs
    // read all-zero during reset, not just the registered ones.
    logic cpu_req_v, gp_req_v, cpu_sel, gp_sel;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l == '0)
            return LEN_W'(1);
        if (l > LEN_W'(BURST_MAX))
            return LEN_W'(BURST_MAX);
        return l;
    endfunction

    always_comb begin
        state_d     = state_q;
        last_gp_d   = last_gp_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        gp_rvalid_d = 1'b0;

        cpu_stall = 1'b0;
        gp_grant  = 1'b0;
        gp_wack   = 1'b0;
        gp_done   = 1'b0;
        mem_addr  = '0;
        mem_we    = '0;
        mem_re    = 1'b0;
        mem_din   = '0;

        cpu_req_v = cpu_req & rst;
        gp_req_v  = gp_req & rst;
        // last_gp_q=1 means GP was served last, so CPU wins a tie.
        cpu_sel   = cpu_req_v & (~gp_req_v | last_gp_q);
        gp_sel    = gp_req_v & (~cpu_req_v | ~last_gp_q);

        unique case (state_q)
            IDLE: begin
                if (cpu_sel) begin
                    mem_addr  = cpu_addr;
                    mem_we    = cpu_we;
                    mem_re    = (cpu_we == 4'h0);
                    mem_din   = cpu_din;
                    cpu_stall = ~mem_ready;
                    if (mem_ready)
                        last_gp_d = 1'b0;
                end else if (gp_sel) begin
                    // Grant cycle only latches the burst; first beat next cycle.
                    gp_grant   = 1'b1;
                    addr_d     = gp_addr;
                    wr_d       = gp_wr;
                    len_d      = clamp_len(gp_len);
                    beat_cnt_d = '0;
                    state_d    = GP_BURST;
                    cpu_stall  = cpu_req_v;
                end
            end
            GP_BURST: begin
                mem_addr  = addr_q;
                mem_we    = wr_q ? 4'hF : 4'h0;
                mem_re    = ~wr_q;
                mem_din   = gp_wdata;
                cpu_stall = cpu_req_v;
                if (mem_ready) begin
                    addr_d      = addr_q + 32'd4;
                    beat_cnt_d  = beat_cnt_q + LEN_W'(1);
                    gp_wack     = wr_q;
                    gp_rvalid_d = ~wr_q;
                    if (beat_cnt_q == len_q - LEN_W'(1))
                        state_d = GP_DRAIN;
                end
            end
            GP_DRAIN: begin
                // Last read beat's data is on mem_dout now (gp_rvalid_q set).
                gp_done   = 1'b1;
                last_gp_d = 1'b1;
                cpu_stall = cpu_req_v;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_gp_q   <= 1'b1;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            gp_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gp_q   <= last_gp_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            gp_rvalid_q <= gp_rvalid_d;
        end
    end

    assign gp_rvalid = gp_rvalid_q;
    assign cpu_dout  = mem_dout;
    assign gp_rdata  = mem_dout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by
// randomized CPU/GP traffic against a word-level shadow memory and
// transaction-level fairness bookkeeping.
module tb_dmem_port_arbiter;
    localparam int BURST_MAX = 8;
    localparam int LEN_W     = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cpu_req;
    logic [31:0]      cpu_addr, cpu_din, cpu_dout;
    logic [3:0]       cpu_we;
    logic             cpu_stall;
    logic             gp_req, gp_wr;
    logic [31:0]      gp_addr, gp_wdata, gp_rdata;
    logic [LEN_W-1:0] gp_len;
    logic             gp_grant, gp_wack, gp_rvalid, gp_done;
    logic [31:0]      mem_addr, mem_din, mem_dout;
    logic [3:0]       mem_we;
    logic             mem_re, mem_ready;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.BURST_MAX(BURST_MAX), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
        .gp_req(gp_req), .gp_addr(gp_addr), .gp_len(gp_len), .gp_wr(gp_wr),
        .gp_wdata(gp_wdata), .gp_grant(gp_grant), .gp_wack(gp_wack),
        .gp_rvalid(gp_rvalid), .gp_rdata(gp_rdata), .gp_done(gp_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ready(mem_ready)
    );

    // Physical memory (what the DUT actually did) and shadow (what it should have done).
    logic [31:0] mem     [0:127];
    logic [31:0] ref_mem [0:127];
    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] winit(input int i);
        return 32'hC0DE0000 ^ (32'(i) * 32'h01030507);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[8:2]);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= winit(i);
            mem_dout <= '0;
        end else if (mem_ready) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[widx(mem_addr)][8*b +: 8] <= mem_din[8*b +: 8];
            if (mem_re) mem_dout <= mem[widx(mem_addr)];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'({cpu_stall, gp_grant, gp_wack, gp_rvalid, gp_done, mem_re, mem_we}), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_addr = '0; cpu_we = '0; cpu_din = '0;
        gp_req = 0; gp_addr = '0; gp_len = '0; gp_wr = 0; gp_wdata = '0;
        mem_ready = 1;
    endtask

    // Ends right after a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        idle_inputs();
        for (int i = 0; i < 128; i++) ref_mem[i] = winit(i);
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    // Call right after a falling edge. Runs one GP burst with an optional
    // mem_ready gap before beat stall_beat, then checks the post-done cycle.
    task automatic gp_burst(input string tag, input logic [31:0] a, input logic [3:0] l,
                            input bit w, input int nb, input int stall_beat,
                            input int stall_cyc, input bit cpu_hold);
        int beats, rv, st, cyc;
        logic [31:0] wd, ea;
        gp_req = 1; gp_addr = a; gp_len = l; gp_wr = w; mem_ready = 1; cpu_req = cpu_hold;
        #4;
        chk({tag, "_grant"}, 32'(gp_grant), 32'd1);
        chk({tag, "_noacc"}, 32'({mem_re, mem_we}), 32'd0);
        chk({tag, "_gstall"}, 32'(cpu_stall), 32'(cpu_hold));
        beats = 0; rv = 0; st = 0; cyc = 0;
        wd = $urandom;
        @(negedge clk);
        // Scramble request fields: the burst must run from latched values.
        gp_req = 0; gp_addr = $urandom; gp_len = 4'($urandom); gp_wr = ~w;
        while (cyc < 40) begin
            cyc++;
            mem_ready = !(beats == stall_beat && st < stall_cyc);
            if (!mem_ready) st++;
            gp_wdata = wd;
            #4;
            if (gp_rvalid) begin
                chk({tag, "_rdata"}, gp_rdata, ref_mem[widx(a + 32'(4*rv))]);
                rv++;
            end
            chk({tag, "_cstall"}, 32'(cpu_stall), 32'(cpu_hold));
            if (gp_done) break;
            ea = a + 32'(4*beats);
            chk({tag, "_addr"}, mem_addr, ea);
            if (w) begin
                chk({tag, "_wack"}, 32'(gp_wack), 32'(mem_ready));
                chk({tag, "_we"}, 32'(mem_we), 32'hF);
                chk({tag, "_din"}, mem_din, wd);
                if (gp_wack) begin
                    ref_mem[widx(ea)] = wd;
                    wd = $urandom;
                end
            end else begin
                chk({tag, "_re"}, 32'(mem_re), 32'd1);
            end
            if (mem_ready) beats++;
            @(negedge clk);
        end
        chk({tag, "_beats"}, 32'(beats), 32'(nb));
        chk({tag, "_rvcnt"}, 32'(rv), w ? 32'd0 : 32'(nb));
        chk({tag, "_donecyc"}, 32'(cyc), 32'(nb + stall_cyc + 1));
        @(negedge clk);
        mem_ready = 1;
        #4;
        chk({tag, "_donepulse"}, 32'({gp_done, gp_rvalid}), 32'd0);
        chk({tag, "_poststall"}, 32'(cpu_stall), 32'd0);
    endtask

    // Random-phase bookkeeping
    bit          cpu_pend, g_pend, g_act, c_rdchk;
    logic [31:0] c_addr, c_din, c_rdval, g_addr, g_ba, gw;
    logic [3:0]  c_we, g_len;
    bit          g_wr;
    int          g_nb, g_wcnt, g_rcnt, c_wait, g_wait;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        for (int i = 0; i < 128; i++) ref_mem[i] = winit(i);
        // Reset state
        @(negedge clk); #4;
        chk_zero("rst_state");

        // 1: lone CPU read right after reset release
        @(negedge clk);
        rst = 1; cpu_req = 1; cpu_addr = 32'h100; cpu_we = 0; mem_ready = 1;
        #4;
        chk("t1_re", 32'(mem_re), 32'd1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_stall", 32'(cpu_stall), 32'd0);
        chk("t1_nogrant", 32'(gp_grant), 32'd0);
        @(negedge clk);
        cpu_req = 0;
        #4;
        chk("t1_rdata", cpu_dout, ref_mem[widx(32'h100)]);

        // 2: GP read burst of 4
        @(negedge clk);
        gp_burst("t2", 32'h10400000, 4'd4, 1'b0, 4, -1, 0, 1'b0);

        // 3: simultaneous requests out of reset -> CPU then GP
        do_reset();
        cpu_req = 1; cpu_addr = 32'h200; cpu_we = 0;
        gp_req = 1; gp_addr = 32'h40; gp_len = 4'd4; gp_wr = 0;
        #4;
        chk("t3_cpufirst", 32'({cpu_stall, gp_grant}), 32'd0);
        chk("t3_addr", mem_addr, 32'h200);
        @(negedge clk);
        cpu_addr = 32'h204;
        gp_burst("t3", 32'h40, 4'd4, 1'b0, 4, -1, 0, 1'b1);
        chk("t3_cpu2", mem_addr, 32'h204);
        @(negedge clk);
        cpu_req = 0;

        // 4: GP write burst of 3, ready low for 2 cycles before beat 2
        gp_burst("t4", 32'h80, 4'd3, 1'b1, 3, 1, 2, 1'b0);

        // 5: length clamping and address wrap
        @(negedge clk);
        gp_burst("t5a", 32'h0C0, 4'd0, 1'b0, 1, -1, 0, 1'b0);
        @(negedge clk);
        gp_burst("t5b", 32'h0E0, 4'd15, 1'b0, 8, -1, 0, 1'b0);
        @(negedge clk);
        gp_burst("t5c", 32'hFFFFFFF8, 4'd4, 1'b0, 4, 2, 1, 1'b0);

        // 6: reset mid-burst
        do_reset();
        gp_req = 1; gp_addr = 32'h300; gp_len = 4'd8; gp_wr = 0;
        #4;
        chk("t6_grant", 32'(gp_grant), 32'd1);
        @(negedge clk);
        gp_req = 0;
        #4;
        chk("t6_b0", mem_addr, 32'h300);
        @(negedge clk); #4;
        chk("t6_b1", mem_addr, 32'h304);
        @(negedge clk);
        cpu_req = 1; cpu_addr = 32'h120; cpu_we = 0; gp_req = 1; rst = 0;
        for (int i = 0; i < 128; i++) ref_mem[i] = winit(i);
        #1;
        chk_zero("t6_rst");
        @(negedge clk); #4;
        chk_zero("t6_rsthold");
        @(negedge clk);
        rst = 1;
        #4;
        chk("t6_cpufirst", 32'({cpu_stall, gp_grant}), 32'd0);
        chk("t6_cpuaddr", mem_addr, 32'h120);
        @(negedge clk);
        cpu_req = 0;
        #4;
        chk("t6_gpnext", 32'(gp_grant), 32'd1);

        // Randomized traffic
        do_reset();
        cpu_pend = 0; g_pend = 0; g_act = 0; c_rdchk = 0; gw = $urandom;
        c_addr = '0; c_din = '0; c_we = '0; g_addr = '0; g_len = '0; g_wr = 0; g_ba = '0;
        g_nb = 0; g_wcnt = 0; g_rcnt = 0; c_wait = 0; g_wait = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit gen;
            gen = (cyc < 3500);
            if (gen && !cpu_pend && $urandom_range(0, 2) == 0) begin
                cpu_pend = 1; c_wait = 0;
                c_addr = {23'h0, 7'($urandom_range(0, 127)), 2'b00};
                c_we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                c_din = $urandom;
            end
            if (gen && !g_pend && !g_act && $urandom_range(0, 4) == 0) begin
                g_pend = 1; g_wait = 0;
                g_addr = {23'h0, 7'($urandom_range(0, 120)), 2'b00};
                g_len = 4'($urandom_range(0, 15));
                g_wr = 1'($urandom_range(0, 1));
                g_nb = (g_len == 0) ? 1 : ((int'(g_len) > BURST_MAX) ? BURST_MAX : int'(g_len));
            end
            cpu_req = cpu_pend; cpu_addr = c_addr; cpu_we = c_we; cpu_din = c_din;
            gp_req = g_pend; gp_addr = g_addr; gp_len = g_len; gp_wr = g_wr; gp_wdata = gw;
            mem_ready = ($urandom_range(0, 3) != 0);
            #4;
            if (c_rdchk) begin
                chk("r_cpu_rdata", cpu_dout, c_rdval);
                c_rdchk = 0;
            end
            if (gp_rvalid) begin
                chk("r_rv_expected", 32'(g_act && !g_wr), 32'd1);
                chk("r_gp_rdata", gp_rdata, ref_mem[widx(g_ba + 32'(4*g_rcnt))]);
                g_rcnt++;
            end
            if (!cpu_pend) chk("r_stall_noreq", 32'(cpu_stall), 32'd0);
            if (cpu_pend && !cpu_stall) begin
                chk("r_cpu_vs_gp", 32'(g_act), 32'd0);
                chk("r_cpu_addr", mem_addr, c_addr);
                chk("r_cpu_we", 32'(mem_we), 32'(c_we));
                if (c_we != 0) begin
                    chk("r_cpu_din", mem_din, c_din);
                    for (int b = 0; b < 4; b++)
                        if (c_we[b]) ref_mem[widx(c_addr)][8*b +: 8] = c_din[8*b +: 8];
                end else begin
                    chk("r_cpu_re", 32'(mem_re), 32'd1);
                    c_rdchk = 1;
                    c_rdval = ref_mem[widx(c_addr)];
                end
                cpu_pend = 0;
                if (g_pend) begin
                    g_wait++;
                    chk("r_gp_fair", 32'(g_wait <= 1), 32'd1);
                end
            end
            if (gp_grant) begin
                chk("r_grant_req", 32'(g_pend), 32'd1);
                chk("r_grant_noacc", 32'({mem_re, mem_we}), 32'd0);
                g_pend = 0; g_act = 1; g_ba = g_addr; g_wcnt = 0; g_rcnt = 0;
            end
            if (gp_wack) begin
                chk("r_wack_expected", 32'(g_act && g_wr), 32'd1);
                chk("r_w_addr", mem_addr, g_ba + 32'(4*g_wcnt));
                chk("r_w_we", 32'(mem_we), 32'hF);
                chk("r_w_din", mem_din, gw);
                ref_mem[widx(g_ba + 32'(4*g_wcnt))] = gw;
                g_wcnt++;
                gw = $urandom;
            end
            if (gp_done) begin
                chk("r_done_expected", 32'(g_act), 32'd1);
                chk("r_beats", 32'(g_wr ? g_wcnt : g_rcnt), 32'(g_nb));
                g_act = 0;
                if (cpu_pend) begin
                    c_wait++;
                    chk("r_cpu_fair", 32'(c_wait <= 1), 32'd1);
                end
            end
            if (!gen && !cpu_pend && !g_pend && !g_act && !c_rdchk) break;
            @(negedge clk);
        end
        chk("r_drain", 32'({cpu_pend, g_pend, g_act}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
